// File: rtl/arduino_link_rx_if.sv
// Bus bundle between the Arduino link receiver and its neighbours.
// The slave modport is the receiver's view; the master modport drives it.
interface arduino_link_rx_if;
   logic [7:0] ARD_DATA;
   logic       ARD_STB;
   logic       ARD_ACK;
   logic [7:0] PORT_ID;
   logic [7:0] OUT_PORT;
   logic       IO_STRB;
   logic [7:0] IN_DATA;
   logic       INTR_REQ;

   modport master (
      output ARD_DATA, ARD_STB, PORT_ID, OUT_PORT, IO_STRB,
      input  ARD_ACK, IN_DATA, INTR_REQ
   );

   modport slave (
      input  ARD_DATA, ARD_STB, PORT_ID, OUT_PORT, IO_STRB,
      output ARD_ACK, IN_DATA, INTR_REQ
   );
endinterface

// File: rtl/arduino_link_rx.sv
// Arduino->MCU parallel link receiver: 4-phase STB/ACK capture into a
// small FIFO, exposed to the MCU as IN ports with a pop/flush OUT port.
module arduino_link_rx #(
   parameter logic [7:0] DATA_ID   = 8'h6A,
   parameter logic [7:0] STATUS_ID = 8'h6B,
   parameter logic [7:0] CTRL_ID   = 8'h6A,
   parameter int         DEPTH     = 4,
   parameter int         SYNC_STG  = 2,
   parameter int         INTR_LEN  = 2
) (
   input logic              CLK,
   input logic              RESET,
   arduino_link_rx_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(INTR_LEN + 1);

   typedef enum logic [1:0] {
      WAIT_LOW,
      IDLE,
      HOLD
   } state_t;

   logic [SYNC_STG-1:0]      stb_q;
   logic [SYNC_STG-1:0]      vld_q;
   logic [SYNC_STG-1:0][7:0] dat_q;
   logic                     stb_s;
   logic [7:0]               data_s;
   logic                     primed;

   state_t         state_q, state_d;
   logic           ack_q, ack_d;
   logic           push, stall;

   logic [7:0]     mem_q [DEPTH];
   logic [AW-1:0]  rptr_q, rptr_d;
   logic [AW-1:0]  wptr_q, wptr_d;
   logic [AW-1:0]  waddr;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]  intr_q, intr_d;

   logic           full, ctrl_wr, flush, pop, trig;
   logic [7:0]     status;
   logic           unused_ok;

   // vld_q tracks when the synchronizer holds real samples after reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stb_q <= '0;
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         stb_q <= {stb_q[SYNC_STG-2:0], bus.ARD_STB};
         vld_q <= {vld_q[SYNC_STG-2:0], 1'b1};
         dat_q <= {dat_q[SYNC_STG-2:0], bus.ARD_DATA};
      end
   end

   assign stb_s  = stb_q[SYNC_STG-1];
   assign data_s = dat_q[SYNC_STG-1];
   assign primed = vld_q[SYNC_STG-1];
   assign full   = (cnt_q == CW'(DEPTH));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= WAIT_LOW;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      push    = 1'b0;
      stall   = 1'b0;
      unique case (state_q)
         WAIT_LOW: begin
            ack_d = 1'b0;
            if (primed && !stb_s) state_d = IDLE;
         end
         IDLE: begin
            ack_d = 1'b0;
            if (stb_s) begin
               if (!full) begin
                  push    = 1'b1;
                  ack_d   = 1'b1;
                  state_d = HOLD;
               end else begin
                  stall = 1'b1;
               end
            end
         end
         HOLD: begin
            if (!stb_s) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            ack_d   = 1'b0;
            state_d = WAIT_LOW;
         end
      endcase
   end

   assign ctrl_wr = bus.IO_STRB && (bus.PORT_ID == CTRL_ID);
   assign flush   = ctrl_wr && bus.OUT_PORT[1];
   assign pop     = ctrl_wr && bus.OUT_PORT[0] && !flush && (cnt_q != '0);
   assign waddr   = flush ? '0 : wptr_q;
   assign trig    = push && ((cnt_q == '0) || flush);

   // flush is applied before a coincident push
   always_comb begin
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         rptr_d = '0;
         wptr_d = '0;
         cnt_d  = '0;
      end else if (pop) begin
         rptr_d = rptr_q + 1'b1;
         cnt_d  = cnt_q - 1'b1;
      end
      if (push) begin
         wptr_d = waddr + 1'b1;
         cnt_d  = cnt_d + 1'b1;
      end
   end

   always_comb begin
      intr_d = intr_q;
      if (trig)
         intr_d = IW'(INTR_LEN);
      else if (intr_q != '0)
         intr_d = intr_q - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
         intr_q <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         intr_q <= intr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[waddr] <= data_s;
   end

   assign status = {full, (cnt_q != '0), stall, 5'(cnt_q)};

   always_comb begin
      bus.IN_DATA = 8'h00;
      if (bus.PORT_ID == DATA_ID)
         bus.IN_DATA = mem_q[rptr_q];
      else if (bus.PORT_ID == STATUS_ID)
         bus.IN_DATA = status;
   end

   assign bus.ARD_ACK  = ack_q;
   assign bus.INTR_REQ = (intr_q != '0);
   assign unused_ok    = ^bus.OUT_PORT[7:2];

endmodule

// File: tb/tb_arduino_link_rx.sv
// Directed plus randomized bench for arduino_link_rx, checked against
// a queue model of the FIFO and the handshake latency rules.
module tb_arduino_link_rx;

   localparam logic [7:0] DID = 8'h6A;
   localparam logic [7:0] SID = 8'h6B;
   localparam logic [7:0] CID = 8'h6A;
   localparam int DEPTH = 4;
   localparam int LAT   = 3;

   logic CLK = 1'b0;
   logic RESET;
   int   n_cmp = 0;
   int   n_err = 0;
   int   intr_hi = 0;
   logic [7:0] q[$];

   arduino_link_rx_if bus();

   arduino_link_rx dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #10 CLK = ~CLK;

   always @(negedge CLK)
      if (bus.INTR_REQ === 1'b1) intr_hi++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_st(input bit stl);
      int n;
      n = q.size();
      return {n == DEPTH, n != 0, stl, 5'(n)};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic rd(input logic [7:0] id, output logic [7:0] d);
      bus.PORT_ID = id;
      #1;
      d = bus.IN_DATA;
   endtask

   task automatic wr(input logic [7:0] id, input logic [7:0] v);
      bus.PORT_ID  = id;
      bus.OUT_PORT = v;
      bus.IO_STRB  = 1'b1;
      @(negedge CLK);
      bus.IO_STRB  = 1'b0;
      if (id == CID) begin
         if (v[1]) q.delete();
         else if (v[0] && q.size() > 0) void'(q.pop_front());
      end
   endtask

   task automatic wait_ack(input logic lvl, output int e);
      e = 0;
      while (bus.ARD_ACK !== lvl && e < 20) begin
         @(negedge CLK);
         e++;
      end
   endtask

   task automatic send(input logic [7:0] b, output int r, output int f);
      bus.ARD_DATA = b;
      bus.ARD_STB  = 1'b1;
      wait_ack(1'b1, r);
      if (r < 20) q.push_back(b);
      bus.ARD_STB = 1'b0;
      wait_ack(1'b0, f);
      tick(1);
   endtask

   task automatic chk_state(input string tag);
      logic [7:0] d;
      rd(SID, d);
      chk({tag, "_st"}, d, exp_st(1'b0));
      if (q.size() > 0) begin
         rd(DID, d);
         chk({tag, "_hd"}, d, q[0]);
      end
   endtask

   initial begin
      int r, f, i0;
      logic [7:0] d, b;
      RESET        = 1'b1;
      bus.ARD_DATA = 8'h00;
      bus.ARD_STB  = 1'b0;
      bus.PORT_ID  = 8'h00;
      bus.OUT_PORT = 8'h00;
      bus.IO_STRB  = 1'b0;
      tick(3);
      RESET = 1'b0;
      chk("rst_ack", bus.ARD_ACK, 1'b0);
      chk("rst_intr", bus.INTR_REQ, 1'b0);
      rd(SID, d);
      chk("rst_st", d, 8'h00);
      tick(4);

      // 1: single byte, latency and interrupt width
      i0 = intr_hi;
      send(8'hA5, r, f);
      chk("t1_rise", r, LAT);
      chk("t1_fall", f, LAT);
      tick(4);
      chk("t1_intr", intr_hi - i0, 2);
      rd(SID, d);
      chk("t1_st", d, 8'h41);
      rd(DID, d);
      chk("t1_hd", d, 8'hA5);

      // 2: fill, stall on fifth byte, pop releases it
      wr(CID, 8'h01);
      for (int k = 1; k <= 4; k++) begin
         send(8'(k), r, f);
         chk("t2_rise", r, LAT);
      end
      bus.ARD_DATA = 8'h05;
      bus.ARD_STB  = 1'b1;
      tick(8);
      chk("t2_noack", bus.ARD_ACK, 1'b0);
      rd(SID, d);
      chk("t2_stall", d, exp_st(1'b1));
      wr(CID, 8'h01);
      rd(DID, d);
      chk("t2_hd", d, 8'h02);
      wait_ack(1'b1, r);
      chk("t2_ack5", bus.ARD_ACK, 1'b1);
      q.push_back(8'h05);
      bus.ARD_STB = 1'b0;
      wait_ack(1'b0, f);
      tick(1);
      chk_state("t2_full");
      for (int k = 0; k < 2; k++) begin
         chk_state("t2_drain");
         wr(CID, 8'h01);
      end

      // 3: pop coincident with push at count 2
      chk("t3_pre", q.size(), 2);
      bus.ARD_DATA = 8'hC3;
      bus.ARD_STB  = 1'b1;
      tick(2);
      bus.PORT_ID  = CID;
      bus.OUT_PORT = 8'h01;
      bus.IO_STRB  = 1'b1;
      tick(1);
      bus.IO_STRB  = 1'b0;
      chk("t3_ack", bus.ARD_ACK, 1'b1);
      void'(q.pop_front());
      q.push_back(8'hC3);
      bus.ARD_STB = 1'b0;
      wait_ack(1'b0, f);
      tick(1);
      chk_state("t3_pp");

      // 4: flush, then flush coincident with push
      send(8'h99, r, f);
      chk("t4_cnt", q.size(), 3);
      wr(CID, 8'h02);
      rd(SID, d);
      chk("t4_flush", d, 8'h00);
      send(8'h11, r, f);
      send(8'h22, r, f);
      tick(4);
      i0 = intr_hi;
      bus.ARD_DATA = 8'h77;
      bus.ARD_STB  = 1'b1;
      tick(2);
      bus.PORT_ID  = CID;
      bus.OUT_PORT = 8'h03;
      bus.IO_STRB  = 1'b1;
      tick(1);
      bus.IO_STRB  = 1'b0;
      q.delete();
      q.push_back(8'h77);
      bus.ARD_STB = 1'b0;
      wait_ack(1'b0, f);
      tick(4);
      chk_state("t4_fp");
      chk("t4_intr", intr_hi - i0, 2);

      // 5: reset mid-handshake must not recapture
      bus.ARD_DATA = 8'h3C;
      bus.ARD_STB  = 1'b1;
      wait_ack(1'b1, r);
      chk("t5_ack", bus.ARD_ACK, 1'b1);
      RESET = 1'b1;
      tick(1);
      chk("t5_rst", bus.ARD_ACK, 1'b0);
      RESET = 1'b0;
      q.delete();
      tick(10);
      chk("t5_hold", bus.ARD_ACK, 1'b0);
      chk_state("t5_nopush");
      bus.ARD_STB = 1'b0;
      tick(5);
      send(8'h5A, r, f);
      chk("t5_rise", r, LAT);
      chk_state("t5_new");

      // 6: pop on empty and foreign port writes
      wr(CID, 8'h01);
      wr(CID, 8'h01);
      chk_state("t6_empty");
      send(8'h6E, r, f);
      for (int k = 0; k < 6; k++) begin
         b = 8'($urandom_range(0, 255));
         if (b == CID) b = 8'h10;
         wr(b, 8'($urandom_range(0, 255)));
      end
      chk_state("t6_foreign");
      rd(8'hFF, d);
      chk("t6_ff", d, 8'h00);

      // randomized traffic
      for (int k = 0; k < 60; k++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op < 5 && q.size() < DEPTH) begin
            send(8'($urandom_range(0, 255)), r, f);
            chk("rnd_rise", r, LAT);
         end else if (op == 9) begin
            wr(CID, 8'h02);
         end else begin
            wr(CID, 8'h01);
         end
         chk_state("rnd");
      end
      while (q.size() > 0) begin
         chk_state("drain");
         wr(CID, 8'h01);
      end
      chk_state("end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
